// File: rtl/laser_cover_if.sv
// Point-input / result-output bundle for laser_cover_opt.
// COVER is carried only when LASER_COVER_OUT_EN is defined.
interface laser_cover_if #(
  parameter int unsigned NPTS = 40,
  parameter int unsigned CW   = 4
);
  logic          IN_VALID;
  logic [CW-1:0] X;
  logic [CW-1:0] Y;
  logic          BUSY;
  logic [CW-1:0] C1X;
  logic [CW-1:0] C1Y;
  logic [CW-1:0] C2X;
  logic [CW-1:0] C2Y;
  logic          DONE;
`ifdef LASER_COVER_OUT_EN
  logic [$clog2(NPTS+1)-1:0] COVER;

  modport master (output IN_VALID, X, Y,
                  input  BUSY, C1X, C1Y, C2X, C2Y, DONE, COVER);
  modport slave  (input  IN_VALID, X, Y,
                  output BUSY, C1X, C1Y, C2X, C2Y, DONE, COVER);
`else
  modport master (output IN_VALID, X, Y,
                  input  BUSY, C1X, C1Y, C2X, C2Y, DONE);
  modport slave  (input  IN_VALID, X, Y,
                  output BUSY, C1X, C1Y, C2X, C2Y, DONE);
`endif
endinterface

// File: rtl/laser_cover_opt.sv
// Two-circle laser coverage optimiser: centroid seed, then alternating exhaustive raster scans.
// Optional COVER output enabled by LASER_COVER_OUT_EN.
module laser_cover_opt #(
  parameter int unsigned NPTS     = 40,
  parameter int unsigned CW       = 4,
  parameter int unsigned R2       = 16,
  parameter int unsigned MAX_PASS = 8
) (
  input logic          CLK,
  input logic          RST,
  laser_cover_if.slave bus
);
  localparam int unsigned IdxW  = $clog2(NPTS);
  localparam int unsigned AccW  = $clog2(NPTS + 1);
  localparam int unsigned SumW  = CW + $clog2(NPTS);
  localparam int unsigned CandW = 2 * CW;
  localparam int unsigned PassW = $clog2(MAX_PASS + 1);
  localparam int unsigned SqW   = 2 * CW;
  localparam int unsigned DW    = 2 * CW + 1;

  localparam logic [AccW-1:0]  LastRd   = AccW'(NPTS - 1);
  localparam logic [AccW-1:0]  EvalEnd  = AccW'(NPTS);
  localparam logic [CandW-1:0] LastCand = '1;
  localparam logic [PassW-1:0] LastPass = PassW'(MAX_PASS - 1);

  typedef enum logic [2:0] {StRead, StCent, StEval0, StScan1, StScan2, StOut} state_e;

  state_e           state_q, state_d;
  logic [AccW-1:0]  cnt_q, cnt_d;
  logic [CandW-1:0] cand_q, cand_d;
  logic [PassW-1:0] pass_q, pass_d;
  logic             improved_q, improved_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [AccW-1:0]  best_q, best_d;
  logic [CW-1:0]    w1x_q, w1y_q, w2x_q, w2y_q;
  logic [CW-1:0]    w1x_d, w1y_d, w2x_d, w2y_d;
  logic [SumW-1:0]  sum_x_q, sum_y_q, sum_x_d, sum_y_d;
  logic [CW-1:0]    c1x_q, c1y_q, c2x_q, c2y_q;

  logic [CW-1:0]    pts_x_q [NPTS];
  logic [CW-1:0]    pts_y_q [NPTS];

  logic [IdxW-1:0]  pt_sel;
  logic [CW-1:0]    px, py, cand_x, cand_y, cent_x, cent_y;
  logic [CW-1:0]    e1x, e1y, e2x, e2y;
  logic             pt_hit, commit;

  // True absolute difference, no modular wrap.
  function automatic logic covers(input logic [CW-1:0] ax, ay, bx, by);
    logic [CW-1:0]  dx, dy;
    logic [SqW-1:0] dx2, dy2;
    logic [DW-1:0]  d2;
    dx  = (ax > bx) ? ax - bx : bx - ax;
    dy  = (ay > by) ? ay - by : by - ay;
    dx2 = SqW'(dx) * SqW'(dx);
    dy2 = SqW'(dy) * SqW'(dy);
    d2  = DW'(dx2) + DW'(dy2);
    return 32'(d2) <= R2;
  endfunction

  assign pt_sel = cnt_q[IdxW-1:0];
  assign px     = pts_x_q[pt_sel];
  assign py     = pts_y_q[pt_sel];
  assign cand_x = cand_q[CandW-1:CW];
  assign cand_y = cand_q[CW-1:0];
  assign cent_x = CW'(sum_x_q / SumW'(NPTS));
  assign cent_y = CW'(sum_y_q / SumW'(NPTS));

  // The scanned circle takes the candidate; the other stays at its working centre.
  always_comb begin
    e1x = w1x_q;
    e1y = w1y_q;
    e2x = w2x_q;
    e2y = w2y_q;
    if (state_q == StScan1) begin
      e1x = cand_x;
      e1y = cand_y;
    end
    if (state_q == StScan2) begin
      e2x = cand_x;
      e2y = cand_y;
    end
  end

  assign pt_hit = covers(px, py, e1x, e1y) | covers(px, py, e2x, e2y);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    pass_d     = pass_q;
    improved_d = improved_q;
    acc_d      = acc_q;
    best_d     = best_q;
    w1x_d      = w1x_q;
    w1y_d      = w1y_q;
    w2x_d      = w2x_q;
    w2y_d      = w2y_q;
    sum_x_d    = sum_x_q;
    sum_y_d    = sum_y_q;
    commit     = 1'b0;
    unique case (state_q)
      StRead: begin
        if (bus.IN_VALID) begin
          sum_x_d = sum_x_q + SumW'(bus.X);
          sum_y_d = sum_y_q + SumW'(bus.Y);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastRd) begin
            cnt_d   = '0;
            state_d = StCent;
          end
        end
      end
      StCent: begin
        w1x_d   = cent_x;
        w1y_d   = cent_y;
        w2x_d   = cent_x;
        w2y_d   = cent_y;
        cnt_d   = '0;
        acc_d   = '0;
        pass_d  = '0;
        state_d = StEval0;
      end
      StEval0, StScan1, StScan2: begin
        if (cnt_q != EvalEnd) begin
          acc_d = acc_q + AccW'(pt_hit);
          cnt_d = cnt_q + 1'b1;
        end else begin
          acc_d = '0;
          cnt_d = '0;
          if (state_q == StEval0) begin
            best_d     = acc_q;
            cand_d     = '0;
            improved_d = 1'b0;
            state_d    = StScan1;
          end else begin
            commit = (acc_q > best_q);
            if (commit) begin
              best_d     = acc_q;
              improved_d = 1'b1;
              if (state_q == StScan1) begin
                w1x_d = cand_x;
                w1y_d = cand_y;
              end else begin
                w2x_d = cand_x;
                w2y_d = cand_y;
              end
            end
            cand_d = cand_q + 1'b1;
            if (cand_q == LastCand) begin
              if (state_q == StScan1) begin
                state_d = StScan2;
              end else begin
                pass_d     = pass_q + 1'b1;
                improved_d = 1'b0;
                if (!(improved_q || commit) || pass_q == LastPass) state_d = StOut;
                else state_d = StScan1;
              end
            end
          end
        end
      end
      StOut: begin
        cnt_d   = '0;
        sum_x_d = '0;
        sum_y_d = '0;
        state_d = StRead;
      end
      default: state_d = StRead;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StRead;
      cnt_q      <= '0;
      cand_q     <= '0;
      pass_q     <= '0;
      improved_q <= 1'b0;
      acc_q      <= '0;
      best_q     <= '0;
      w1x_q      <= '0;
      w1y_q      <= '0;
      w2x_q      <= '0;
      w2y_q      <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      pass_q     <= pass_d;
      improved_q <= improved_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      w1x_q      <= w1x_d;
      w1y_q      <= w1y_d;
      w2x_q      <= w2x_d;
      w2y_q      <= w2y_d;
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && state_q == StRead && bus.IN_VALID) begin
      pts_x_q[pt_sel] <= bus.X;
      pts_y_q[pt_sel] <= bus.Y;
    end
  end

  // Results are loaded on entry to OUT so they are valid alongside DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      c1x_q <= '0;
      c1y_q <= '0;
      c2x_q <= '0;
      c2y_q <= '0;
    end else if (state_d == StOut) begin
      c1x_q <= w1x_d;
      c1y_q <= w1y_d;
      c2x_q <= w2x_d;
      c2y_q <= w2y_d;
    end
  end

`ifdef LASER_COVER_OUT_EN
  logic [AccW-1:0] cover_q;
  always_ff @(posedge CLK) begin
    if (RST) cover_q <= '0;
    else if (state_d == StOut) cover_q <= best_d;
  end
  assign bus.COVER = cover_q;
`endif

  assign bus.C1X  = c1x_q;
  assign bus.C1Y  = c1y_q;
  assign bus.C2X  = c2x_q;
  assign bus.C2Y  = c2y_q;
  assign bus.DONE = (state_q == StOut);
  assign bus.BUSY = (state_q != StRead);

endmodule

// File: tb/tb_laser_cover_opt.sv
// Bench for laser_cover_opt: small-grid instances (MAX_PASS 8 and 1) checked against a
// behavioural model, plus one default-parameter instance for the full-size latency case.
module tb_laser_cover_opt;
  localparam int NS = 8;
  localparam int CWS = 3;
  localparam int R2S = 4;
  localparam int G = 8;
  localparam int NB = 40;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_s;
  logic rst_b;

  laser_cover_if #(.NPTS(NS), .CW(CWS)) bus_a ();
  laser_cover_if #(.NPTS(NS), .CW(CWS)) bus_p ();
  laser_cover_if bus_b ();

  laser_cover_opt #(.NPTS(NS), .CW(CWS), .R2(R2S), .MAX_PASS(8)) u_a (
    .CLK(CLK), .RST(rst_s), .bus(bus_a)
  );
  laser_cover_opt #(.NPTS(NS), .CW(CWS), .R2(R2S), .MAX_PASS(1)) u_p (
    .CLK(CLK), .RST(rst_s), .bus(bus_p)
  );
  laser_cover_opt u_big (
    .CLK(CLK), .RST(rst_b), .bus(bus_b)
  );

  int n_chk = 0;
  int n_pass = 0;
  int px[NS];
  int py[NS];

  typedef struct {
    int ax, ay, na, bx, by;
    int e1x, e1y, e2x, e2y, ecov, epass;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int pack4(input int a, input int b, input int c, input int d);
    return (a << 12) | (b << 8) | (c << 4) | d;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 0) ? bus_a.DONE : bus_p.DONE;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? bus_a.BUSY : bus_p.BUSY;
  endfunction
  function automatic int cent_of(input int w);
    if (w == 0) return pack4(int'(bus_a.C1X), int'(bus_a.C1Y), int'(bus_a.C2X), int'(bus_a.C2Y));
    return pack4(int'(bus_p.C1X), int'(bus_p.C1Y), int'(bus_p.C2X), int'(bus_p.C2Y));
  endfunction
`ifdef LASER_COVER_OUT_EN
  function automatic int cover_of(input int w);
    return (w == 0) ? int'(bus_a.COVER) : int'(bus_p.COVER);
  endfunction
`endif

  // Reference model: direct coverage counting over the stored frame.
  function automatic bit in_r(input int x0, input int y0, input int cx, input int cy);
    return (x0 - cx) * (x0 - cx) + (y0 - cy) * (y0 - cy) <= R2S;
  endfunction
  function automatic int cov(input int ax, input int ay, input int bx, input int by);
    int n = 0;
    for (int i = 0; i < NS; i++) if (in_r(px[i], py[i], ax, ay) || in_r(px[i], py[i], bx, by)) n++;
    return n;
  endfunction
  task automatic model(input int maxp, output int c1x, output int c1y, output int c2x,
                       output int c2y, output int best, output int passes);
    int sx = 0;
    int sy = 0;
    int v;
    bit imp;
    for (int i = 0; i < NS; i++) begin
      sx += px[i];
      sy += py[i];
    end
    c1x = sx / NS; c1y = sy / NS; c2x = c1x; c2y = c1y;
    best = cov(c1x, c1y, c2x, c2y);
    passes = 0;
    do begin
      imp = 0;
      for (int x = 0; x < G; x++) for (int y = 0; y < G; y++) begin
        v = cov(x, y, c2x, c2y);
        if (v > best) begin c1x = x; c1y = y; best = v; imp = 1; end
      end
      for (int x = 0; x < G; x++) for (int y = 0; y < G; y++) begin
        v = cov(c1x, c1y, x, y);
        if (v > best) begin c2x = x; c2y = y; best = v; imp = 1; end
      end
      passes++;
    end while (imp && passes < maxp);
  endtask

  function automatic int lat_small(input int p);
    return 1 + (NS + 1) * (1 + 2 * p * G * G);
  endfunction

  task automatic drive(input logic v, input int x, input int y);
    bus_a.IN_VALID = v; bus_a.X = CWS'(x); bus_a.Y = CWS'(y);
    bus_p.IN_VALID = v; bus_p.X = CWS'(x); bus_p.Y = CWS'(y);
  endtask

  task automatic set_frame(input int ax, input int ay, input int na, input int bx, input int by);
    for (int i = 0; i < NS; i++) begin
      px[i] = (i < na) ? ax : bx;
      py[i] = (i < na) ? ay : by;
    end
  endtask

  // Returns just after the edge that accepts the last point.
  task automatic feed_small(input bit gaps);
    for (int i = 0; i < NS; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin
        @(negedge CLK);
        drive(1'b0, $urandom_range(0, G - 1), $urandom_range(0, G - 1));
      end
      @(negedge CLK);
      drive(1'b1, px[i], py[i]);
    end
    @(posedge CLK);
    #1 drive(1'b0, 0, 0);
  endtask

  task automatic wait_check(input int w, input string tag, input int elat, input int ecent,
                            input int ecov);
    int lat = 0;
    int held;
    while (!done_of(w) && lat < 20000) begin
      @(posedge CLK);
      #1 lat++;
    end
    chk({tag, " latency"}, lat, elat);
    chk({tag, " centres"}, cent_of(w), ecent);
`ifdef LASER_COVER_OUT_EN
    chk({tag, " cover"}, cover_of(w), ecov);
`else
    if (ecov < 0) $display("note: negative cover expectation for %s", tag);
`endif
    held = cent_of(w);
    @(posedge CLK);
    #1;
    chk({tag, " done one cycle"}, done_of(w), 0);
    chk({tag, " busy after out"}, busy_of(w), 0);
    chk({tag, " centres held"}, cent_of(w), ecent);
    if (held != cent_of(w)) $display("note: %s centres moved after DONE", tag);
  endtask

  task automatic run_frame(input string tag, input bit gaps, input bit junk, input int e1x,
                           input int e1y, input int e2x, input int e2y, input int ecov,
                           input int epass);
    int q1x, q1y, q2x, q2y, qcov, qpass;
    model(1, q1x, q1y, q2x, q2y, qcov, qpass);
    feed_small(gaps);
    fork
      wait_check(0, {tag, " mp8"}, lat_small(epass), pack4(e1x, e1y, e2x, e2y), ecov);
      wait_check(1, {tag, " mp1"}, lat_small(qpass), pack4(q1x, q1y, q2x, q2y), qcov);
      if (junk) begin
        repeat (300) begin
          @(negedge CLK);
          drive(1'($urandom_range(0, 1)), $urandom_range(0, G - 1), $urandom_range(0, G - 1));
        end
        @(negedge CLK);
        drive(1'b0, 0, 0);
      end
    join
  endtask

  task automatic check_reset(input string tag);
    for (int w = 0; w < 2; w++) begin
      chk({tag, " centres"}, cent_of(w), 0);
      chk({tag, " done"}, done_of(w), 0);
      chk({tag, " busy"}, busy_of(w), 0);
`ifdef LASER_COVER_OUT_EN
      chk({tag, " cover"}, cover_of(w), 0);
`endif
    end
  endtask

  initial begin
    int m1x, m1y, m2x, m2y, mcov, mpass;
    tbl[0] = '{1, 1, 4, 6, 6, 0, 0, 4, 6, 8, 2};
    tbl[1] = '{0, 0, 4, 7, 7, 0, 0, 5, 7, 8, 2};
    tbl[2] = '{7, 0, 8, 0, 0, 7, 0, 7, 0, 8, 1};
    tbl[3] = '{5, 5, 8, 5, 5, 5, 5, 5, 5, 8, 1};
    rst_s = 1'b1;
    rst_b = 1'b1;
    drive(1'b0, 0, 0);
    bus_b.IN_VALID = 1'b0; bus_b.X = '0; bus_b.Y = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset("reset");
    fork
      begin : small_tests
        @(negedge CLK) rst_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
          set_frame(tbl[i].ax, tbl[i].ay, tbl[i].na, tbl[i].bx, tbl[i].by);
          run_frame($sformatf("vec%0d", i), 1'b0, 1'b0, tbl[i].e1x, tbl[i].e1y, tbl[i].e2x,
                    tbl[i].e2y, tbl[i].ecov, tbl[i].epass);
        end
        // Same single-cluster frame with input gaps and ignored pulses while busy.
        run_frame("gaps", 1'b1, 1'b1, 5, 5, 5, 5, 8, 1);
        // Reset during SCAN2 of the first pass, with a point offered in the reset cycle.
        set_frame(1, 1, 4, 6, 6);
        feed_small(1'b0);
        repeat (900) @(posedge CLK);
        @(negedge CLK);
        rst_s = 1'b1;
        drive(1'b1, 7, 7);
        @(posedge CLK);
        #1 check_reset("scan2 reset");
        @(negedge CLK);
        rst_s = 1'b0;
        drive(1'b0, 0, 0);
        set_frame(5, 5, 8, 5, 5);
        run_frame("post reset", 1'b0, 1'b0, 5, 5, 5, 5, 8, 1);
        // Partial frame discarded by a reset mid-READ.
        for (int i = 0; i < 5; i++) begin
          @(negedge CLK);
          drive(1'b1, 7, 7);
        end
        @(negedge CLK);
        rst_s = 1'b1;
        drive(1'b1, 7, 7);
        @(negedge CLK);
        rst_s = 1'b0;
        drive(1'b0, 0, 0);
        set_frame(1, 1, 4, 6, 6);
        run_frame("read reset", 1'b0, 1'b0, 0, 0, 4, 6, 8, 2);
        for (int r = 0; r < 6; r++) begin
          for (int i = 0; i < NS; i++) begin
            px[i] = $urandom_range(0, G - 1);
            py[i] = $urandom_range(0, G - 1);
          end
          model(8, m1x, m1y, m2x, m2y, mcov, mpass);
          run_frame($sformatf("rand%0d", r), r[0], 1'b0, m1x, m1y, m2x, m2y, mcov, mpass);
        end
      end
      begin : big_test
        int lat = 0;
        @(negedge CLK) rst_b = 1'b0;
        chk("big reset centres", pack4(int'(bus_b.C1X), int'(bus_b.C1Y), int'(bus_b.C2X),
            int'(bus_b.C2Y)), 0);
        chk("big reset busy", bus_b.BUSY, 0);
        for (int i = 0; i < NB; i++) begin
          @(negedge CLK);
          bus_b.IN_VALID = 1'b1; bus_b.X = 4'd5; bus_b.Y = 4'd5;
        end
        @(posedge CLK);
        #1 bus_b.IN_VALID = 1'b0;
        while (!bus_b.DONE && lat < 30000) begin
          @(posedge CLK);
          #1 lat++;
        end
        chk("big latency", lat, 21034);
        chk("big centres", pack4(int'(bus_b.C1X), int'(bus_b.C1Y), int'(bus_b.C2X),
            int'(bus_b.C2Y)), pack4(5, 5, 5, 5));
`ifdef LASER_COVER_OUT_EN
        chk("big cover", int'(bus_b.COVER), NB);
`endif
        @(posedge CLK);
        #1 chk("big done one cycle", bus_b.DONE, 0);
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/laser_cover_opt.md
# laser_cover_opt

- Parametrised two-circle laser coverage optimiser.
- Accepts a frame of NPTS target points through a valid-qualified input.
- Places two circles of squared radius R2 on a 2^CW × 2^CW grid to maximise the number of points covered by their union, using alternating exhaustive per-circle raster scans.
- Sits in the same LASER datapath as the fixed 40-point, 4-bit hill-climbing engine and supersedes it where point count, grid width, radius or runtime bound differ.

## Interface
Parameters:
- NPTS, 40 — points per frame (≥2)
- CW, 4 — coordinate width; grid is 2^CW per axis
- R2, 16 — squared radius; a point is covered iff dx²+dy² ≤ R2
- MAX_PASS, 8 — maximum optimisation passes per frame (≥1)

Ports (one clock CLK; RST synchronous, active-high):
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- IN_VALID  in  1  X/Y hold a point this cycle
- X  in  CW  point x
- Y  in  CW  point y
- BUSY  out  1  high in every state except READ
- C1X, C1Y, C2X, C2Y  out  CW  result centres
- DONE  out  1  one-cycle result strobe
- COVER  out  $clog2(NPTS+1)  covered-point count; present only with LASER_COVER_OUT_EN

## Operation
States: READ → CENT → EVAL0 → SCAN1 → SCAN2 → (SCAN1 | OUT) → READ.

- **READ:** a point is stored at index cnt when IN_VALID=1; IN_VALID=0 cycles are ignored. After point NPTS-1 is stored, go to CENT.
- **CENT (1 cycle):** set both working centres to (floor(ΣX/NPTS), floor(ΣY/NPTS)). Sum width is CW+$clog2(NPTS).
- **EVAL0:** compute the coverage of the current pair into best.
- **SCAN1:** circle 2 is fixed. Evaluate every candidate c1 in raster order, index = x·2^CW + y, x-major, from 0 to 4^CW−1.
  - Replace the working c1 and best only if the union coverage is strictly greater; ties keep the earlier value.
- **SCAN2:** same as SCAN1 with circle 1 fixed.
- A pass is SCAN1 followed by SCAN2. After SCAN2:
  - go to OUT if the pass produced no replacement, or if the pass count equals MAX_PASS;
  - otherwise go to SCAN1.
- **OUT (1 cycle):** load C1X..C2Y (and COVER) from the working registers; DONE=1. The next state is READ with cnt=0.
- **Distance arithmetic:** dx=|a−b| uses a true absolute difference with no modular wrap. Squares use 2·CW bits; the sum uses 2·CW+1 bits; the comparison is unsigned against R2.
- Outputs hold their values until the next OUT or RST.
- IN_VALID while BUSY=1 is ignored; the point is dropped and not queued.

## Timing
- Candidate evaluation takes NPTS+1 cycles: NPTS cycles of one-point-per-cycle accumulate, then 1 compare/commit cycle. EVAL0 also takes NPTS+1 cycles.
- A scan takes 4^CW·(NPTS+1) cycles.
- DONE rises 1 + (NPTS+1)·(1 + 2·P·4^CW) cycles after the edge that accepts the last point, where P is the number of passes run.
  - Example: CW=4, NPTS=40, P=1 gives 21034 cycles.
- DONE is a decode of the registered state, so it is glitch-free and high for exactly one cycle.
- BUSY falls in the cycle after OUT.
- Reset values: C1X=C1Y=C2X=C2Y=0, DONE=0, BUSY=0, COVER=0; state=READ, cnt=0.
- RST asserted in any state, including mid-scan or mid-READ:
  - the next cycle is READ with all outputs at their reset values;
  - the partial frame is discarded.
- If RST and IN_VALID are high in the same cycle, reset wins and the point is not stored.

## Configuration
- LASER_COVER_OUT_EN defined:
  - the COVER port exists;
  - it is loaded with best at OUT and reset to 0.
- Undefined:
  - the port is absent;
  - best is still computed internally;
  - all other behaviour and timing are identical.

## Test plan
All cases use defaults unless stated.
- **All 40 points at (5,5):** C1=C2=(5,5), COVER=40, P=1, DONE exactly 21034 cycles after the last accept.
- **20 points at (2,2), 20 at (13,13):** centroid (7,7) covers 0. Expect C1=(0,0), C2=(9,13), COVER=40, P=2.
- **No-wrap check, 20 points at (0,0), 20 at (15,15):** C1=(0,0), C2=(11,15), COVER=40. A wrapped difference would wrongly give C1 covering 40.
- **Same frame as case 1 with random IN_VALID=0 gaps and extra IN_VALID pulses while BUSY:** identical result and identical DONE latency measured from the last accepted point.
- **RST pulse mid-SCAN2 of case 2:** next cycle outputs are 0, BUSY=0, DONE=0. A fresh case-1 frame then yields (5,5)/(5,5).
- **MAX_PASS=1 with case 2:** DONE after exactly one pass with C1=(0,0), C2=(9,13).
